mem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-ported synchronous word memory (17-bit word address [15:31], 4 byte-lane write enables, 32-bit data) between the CPU and an I/O processor (IOP) DMA port.
- Sits between the CPU/IOP memory buses and the Memory block; replaces the direct CPU-to-memory connection.
- Fixed CPU priority with IOP starvation guard, optional round-robin, and a CPU bus lock for read-modify-write sequences.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous word memory between the CPU and the IOP DMA port.
// Bit 0 of each bus in the original big-endian numbering maps to the MSB here (for example, c_addr[16] is address bit 15).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,    // 1..15
  parameter bit          ROUND_ROBIN  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,                  // asynchronous, active low

  input  logic        c_req,
  input  logic        c_lock,
  input  logic [16:0] c_addr,
  input  logic [3:0]  c_wr_en,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,

  input  logic        io_req,
  input  logic [16:0] io_addr,
  input  logic [3:0]  io_wr_en,
  input  logic [31:0] io_wdata,
  output logic        io_gnt,
  output logic        io_rvalid,
  output logic [31:0] io_rdata,

  output logic [16:0] mem_address,
  output logic [3:0]  mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic { OWNER_CPU, OWNER_IOP } owner_e;
  typedef enum logic [1:0] { WIN_NONE, WIN_CPU, WIN_IOP } win_e;

  win_e        win;
  owner_e      last_owner;
  logic        lock_active;
  logic [3:0]  starve_cnt;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;

  // Priority: bus lock, then the starvation guard, then round-robin or CPU priority.
  always_comb begin
    win = WIN_NONE;
    if (lock_active) begin
      if (c_req) win = WIN_CPU;
    end else if (io_req && (starve_cnt == LIMIT)) begin
      win = WIN_IOP;
    end else if (ROUND_ROBIN && c_req && io_req) begin
      win = (last_owner == OWNER_CPU) ? WIN_IOP : WIN_CPU;
    end else if (c_req) begin
      win = WIN_CPU;
    end else if (io_req) begin
      win = WIN_IOP;
    end
  end

  // Grants are combinational, so they are gated here to stay low for the whole time reset is held.
  assign c_gnt  = reset && (win == WIN_CPU);
  assign io_gnt = reset && (win == WIN_IOP);

  // NOTE: every output of this block gets a default first, so no latch can be inferred on an idle cycle.
  always_comb begin
    mem_address  = addr_q;
    mem_data_in  = wdata_q;
    mem_write_en = '0;
    if (c_gnt) begin
      mem_address  = c_addr;
      mem_data_in  = c_wdata;
      mem_write_en = c_wr_en;
    end else if (io_gnt) begin
      mem_address  = io_addr;
      mem_data_in  = io_wdata;
      mem_write_en = io_wr_en;
    end
  end

  assign c_rdata  = mem_data_out;
  assign io_rdata = mem_data_out;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      c_rvalid    <= 1'b0;
      io_rvalid   <= 1'b0;
      starve_cnt  <= '0;
      lock_active <= 1'b0;
      last_owner  <= OWNER_CPU;
    end else begin
      c_rvalid    <= c_gnt && (c_wr_en == 4'b0000);
      io_rvalid   <= io_gnt && (io_wr_en == 4'b0000);
      lock_active <= c_lock && (lock_active || c_gnt);

      if (c_gnt || io_gnt) begin
        addr_q  <= mem_address;
        wdata_q <= mem_data_in;
      end

      if (c_gnt)       last_owner <= OWNER_CPU;
      else if (io_gnt) last_owner <= OWNER_IOP;

      if (io_req && !io_gnt) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a CPU-priority and a round-robin instance share stimulus, each with its own memory.
// Reads are scoreboarded; grants and memory-bus values are compared against a reference model every cycle.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        c_req, c_lock, io_req;
  logic [16:0] c_addr, io_addr;
  logic [3:0]  c_we, io_we;
  logic [31:0] c_wd, io_wd;

  logic [1:0]       c_gnt, io_gnt, c_rvalid, io_rvalid;
  logic [1:0][31:0] c_rdata, io_rdata, mem_din, mem_q;
  logic [1:0][16:0] mem_addr;
  logic [1:0][3:0]  mem_we;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .ROUND_ROBIN(1'b0)) dut_pri (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_lock(c_lock), .c_addr(c_addr), .c_wr_en(c_we), .c_wdata(c_wd),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]),
    .io_req(io_req), .io_addr(io_addr), .io_wr_en(io_we), .io_wdata(io_wd),
    .io_gnt(io_gnt[0]), .io_rvalid(io_rvalid[0]), .io_rdata(io_rdata[0]),
    .mem_address(mem_addr[0]), .mem_write_en(mem_we[0]), .mem_data_in(mem_din[0]),
    .mem_data_out(mem_q[0])
  );

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .ROUND_ROBIN(1'b1)) dut_rr (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_lock(c_lock), .c_addr(c_addr), .c_wr_en(c_we), .c_wdata(c_wd),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]),
    .io_req(io_req), .io_addr(io_addr), .io_wr_en(io_we), .io_wdata(io_wd),
    .io_gnt(io_gnt[1]), .io_rvalid(io_rvalid[1]), .io_rdata(io_rdata[1]),
    .mem_address(mem_addr[1]), .mem_write_en(mem_we[1]), .mem_data_in(mem_din[1]),
    .mem_data_out(mem_q[1])
  );

  always #5 clock = ~clock;

  int unsigned cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Behavioural synchronous memories, one per instance, addressed by the low 6 address bits.
  logic [31:0] init_img [2][64];
  logic [31:0] phys     [2][64];
  bit          loaded = 1'b0;

  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 64; a++) phys[i][a] <= init_img[i][a];
      loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mem_we[i] != 4'b0000)
          phys[i][mem_addr[i][5:0]] <= merge(phys[i][mem_addr[i][5:0]], mem_din[i], mem_we[i]);
        mem_q[i] <= phys[i][mem_addr[i][5:0]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [2][64];
  int          starve [2];
  bit          lock   [2];
  bit          last_io[2];
  logic [16:0] held_addr[2];
  logic [31:0] held_data[2];
  byte         seen   [2];

  typedef struct { int unsigned due; logic [31:0] data; } exp_t;
  exp_t exp_q [4][$];   // index = instance*2 + (0 CPU, 1 IOP)

  function automatic byte model_winner(input int i);
    if (!reset) return "-";
    if (lock[i]) return c_req ? "C" : "-";
    if (io_req && starve[i] >= LIMIT) return "I";
    if (i == 1 && c_req && io_req) return last_io[i] ? "C" : "I";
    if (c_req) return "C";
    if (io_req) return "I";
    return "-";
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      starve[i] = 0; lock[i] = 1'b0; last_io[i] = 1'b0;
      held_addr[i] = '0; held_data[i] = '0;
    end
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  // Scoreboard monitor: every read must show up exactly one cycle after its grant.
  initial begin
    string pname [4];
    logic v;
    logic [31:0] d;
    pname = '{"c_rvalid_pri", "io_rvalid_pri", "c_rvalid_rr", "io_rvalid_rr"};
    forever begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        v = (k % 2 == 0) ? c_rvalid[k/2] : io_rvalid[k/2];
        d = (k % 2 == 0) ? c_rdata[k/2]  : io_rdata[k/2];
        if (exp_q[k].size() > 0 && exp_q[k][0].due == cycle) begin
          check(pname[k], 32'(v), 32'd1);
          if (v) check({pname[k], "_data"}, d, exp_q[k][0].data);
          void'(exp_q[k].pop_front());
        end else begin
          check(pname[k], 32'(v), 32'd0);
        end
      end
    end
  end

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    byte w, got;
    logic [16:0] ea;
    logic [31:0] ed;
    logic [3:0]  ewe;
    int          p;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      w   = model_winner(i);
      got = (c_gnt[i] && io_gnt[i]) ? "X" : c_gnt[i] ? "C" : io_gnt[i] ? "I" : "-";
      seen[i] = got;
      check($sformatf("grant_%0d", i), 32'(got), 32'(w));
      ea = held_addr[i]; ed = held_data[i]; ewe = 4'b0000;
      if (w == "C") begin ea = c_addr;  ed = c_wd;  ewe = c_we;  end
      if (w == "I") begin ea = io_addr; ed = io_wd; ewe = io_we; end
      check($sformatf("mem_address_%0d", i),  32'(mem_addr[i]), 32'(ea));
      check($sformatf("mem_write_en_%0d", i), 32'(mem_we[i]),   32'(ewe));
      check($sformatf("mem_data_in_%0d", i),  mem_din[i],       ed);
      if (w != "-") begin
        held_addr[i] = ea; held_data[i] = ed;
        p = i*2 + ((w == "I") ? 1 : 0);
        if (ewe == 4'b0000) exp_q[p].push_back('{due: cycle + 1, data: ref_mem[i][ea[5:0]]});
        else ref_mem[i][ea[5:0]] = merge(ref_mem[i][ea[5:0]], ed, ewe);
      end
      if (reset) begin
        if (io_req && w != "I") starve[i] = (starve[i] < LIMIT) ? starve[i] + 1 : LIMIT;
        else starve[i] = 0;
        lock[i] = c_lock && (lock[i] || w == "C");
        if (w == "C") last_io[i] = 1'b0;
        if (w == "I") last_io[i] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_c(input logic req, input logic lk, input logic [16:0] a,
                       input logic [3:0] we, input logic [31:0] wd);
    c_req = req; c_lock = lk; c_addr = a; c_we = we; c_wd = wd;
  endtask

  task automatic set_io(input logic req, input logic [16:0] a,
                        input logic [3:0] we, input logic [31:0] wd);
    io_req = req; io_addr = a; io_we = we; io_wd = wd;
  endtask

  task automatic idle();
    set_c(1'b0, 1'b0, '0, '0, '0);
    set_io(1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_c_gnt"},     32'(c_gnt),     32'd0);
    check({tag, "_io_gnt"},    32'(io_gnt),    32'd0);
    check({tag, "_c_rvalid"},  32'(c_rvalid),  32'd0);
    check({tag, "_io_rvalid"}, 32'(io_rvalid), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr0"}, 32'(mem_addr[0]), 32'd0);
    check({tag, "_mem_addr1"}, 32'(mem_addr[1]), 32'd0);
    check({tag, "_mem_din0"},  mem_din[0], 32'd0);
    check({tag, "_mem_din1"},  mem_din[1], 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    string pat_pri, pat_rr;
    logic [31:0] v;
    pat_pri = "CCCCICCCCI";
    pat_rr  = "ICICICICIC";
    idle();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 64; a++) begin
        v = $urandom;
        if (a == 16) v = 32'hDEADBEEF;
        if (a == 32) v = 32'hAABBCCDD;
        init_img[i][a] = v;
        ref_mem[i][a]  = v;
      end
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("init");
    reset = 1'b1;

    // Single CPU read of a preloaded word.
    set_c(1'b1, 1'b0, 17'h00010, 4'b0000, '0);
    step();
    check("t1_cpu_gnt", 32'(seen[0]), 32'("C"));
    idle();
    check("t1_rvalid", 32'(c_rvalid[0]), 32'd1);
    check("t1_rdata",  c_rdata[0], 32'hDEADBEEF);
    step();
    check("t1_rvalid_once", 32'(c_rvalid[0]), 32'd0);

    // Partial write then read-back on the next cycle.
    set_c(1'b1, 1'b0, 17'h00020, 4'b0011, 32'h12345678);
    step();
    check("t2_no_rvalid_on_write", 32'(c_rvalid[0]), 32'd0);
    set_c(1'b1, 1'b0, 17'h00020, 4'b0000, '0);
    step();
    idle();
    check("t2_rvalid", 32'(c_rvalid[0]), 32'd1);
    check("t2_rdata",  c_rdata[0], 32'hAABB5678);
    step();

    // Both ports requesting continuously: starvation guard vs round-robin.
    idle();
    do_reset(2);
    set_c(1'b1, 1'b0, 17'h00005, 4'b0000, '0);
    set_io(1'b1, 17'h00006, 4'b0000, '0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t3_starve_pattern_%0d", k), 32'(seen[0]), 32'(pat_pri[k]));
      check($sformatf("t4_rr_pattern_%0d", k),     32'(seen[1]), 32'(pat_rr[k]));
    end
    idle();
    repeat (2) step();

    // Bus lock holds the IOP off past the starvation limit.
    set_c(1'b1, 1'b1, 17'h00007, 4'b0000, '0);
    step();
    check("t5_lock_gnt_pri", 32'(seen[0]), 32'("C"));
    check("t5_lock_gnt_rr",  32'(seen[1]), 32'("C"));
    set_c(1'b0, 1'b1, '0, 4'b0000, '0);
    set_io(1'b1, 17'h00008, 4'b0000, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t5_held_off_%0d", k), 32'({seen[1], seen[0]}), 32'({8'("-"), 8'("-")}));
    end
    c_lock = 1'b0;
    step();
    check("t5_unlock_cycle", 32'(seen[0]), 32'("-"));
    step();
    check("t5_iop_after_unlock", 32'(seen[0]), 32'("I"));

    // Reset asserted while an IOP read is in flight.
    set_io(1'b1, 17'h00010, 4'b0000, '0);
    step();
    check("t6_iop_gnt", 32'(seen[0]), 32'("I"));
    set_c(1'b1, 1'b0, 17'h00011, 4'b0000, '0);
    do_reset(2);
    step();
    check("t6_first_after_reset_pri", 32'(seen[0]), 32'("C"));
    check("t6_first_after_reset_rr",  32'(seen[1]), 32'("I"));

    // Randomized traffic; a pending request keeps its payload until the CPU-priority instance grants it.
    for (int n = 0; n < 400; n++) begin
      if (!c_req || seen[0] == "C" || $urandom_range(7) == 0)
        set_c($urandom_range(2) != 0, 1'b0, 17'($urandom_range(63)),
              ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom), $urandom);
      c_lock = ($urandom_range(4) == 0);
      if (!io_req || seen[0] == "I" || $urandom_range(7) == 0)
        set_io($urandom_range(2) != 0, 17'($urandom_range(63)),
               ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom), $urandom);
      step();
    end

    idle();
    repeat (3) step();
    for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), exp_q[k].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
